pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
IF-stage controller that owns the architectural fetch PC and sequences instruction-memory fetches. It uses a one-outstanding-request handshake and delivers instructions to the IF/ID register with valid/ready. It applies trap and branch/jump redirects from later stages and discards stale in-flight fetches.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
INSTR_BYTES, 4, sequential PC increment.
NOP_INSTR, 32'h0000_0013, value of if_instr at reset and when killed.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-low reset (rst==0 resets on clk edge).
redirect_valid  in  1  branch/jump taken from EX.
redirect_pc  in  32  redirect target.
trap_valid  in  1  trap/exception redirect.
trap_pc  in  32  trap vector target.
imem_req_valid  out  1  fetch request valid.
imem_req_addr  out  32  fetch address.
imem_req_ready  in  1  imem accepts the request.
imem_rsp_valid  in  1  fetch data returned.
imem_rsp_data  in  32  instruction word.
if_valid  out  1  instruction valid to IF/ID.
if_pc  out  32  PC of the delivered instruction.
if_instr  out  32  delivered instruction.
if_ready  in  1  IF/ID accepts; low means stall.
misaligned_o  out  1  one-cycle pulse when the applied target has bits[1:0] != 0.

Behaviour:
- All outputs are registered.
- Reset (rst==0 at clk edge):
  - pc=RESET_VECTOR, state=IDLE, drop=0.
  - imem_req_valid=0, imem_req_addr=RESET_VECTOR.
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR, misaligned_o=0.
  - Reset mid-operation abandons everything. imem shares rst and discards its in-flight responses.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE -> REQ on the first cycle after reset release.
  - REQ: imem_req_valid=1, imem_req_addr=pc. Valid and addr are held stable until imem_req_valid&&imem_req_ready. On accept: fetch_pc<=pc, pc<=pc+INSTR_BYTES (mod 2^32, wraps 0xFFFF_FFFC->0), go to WAIT.
  - WAIT: imem_req_valid=0. On imem_rsp_valid:
    - drop==1: discard the response, clear drop, go to REQ.
    - drop==0: if_valid<=1, if_pc<=fetch_pc, if_instr<=imem_rsp_data, go to HOLD.
  - HOLD: if_valid, if_pc and if_instr are held until if_ready. On if_valid&&if_ready: if_valid<=0, go to REQ.
- Throughput is one instruction per 3 cycles at zero imem latency. No overlap.
- Redirect priority: trap_valid > redirect_valid > sequential.
  - Target T = trap_pc if trap_valid, else redirect_pc.
  - pc <= {T[31:2],2'b00}. misaligned_o<=1 for one cycle if T[1:0]!=0.
- Redirect per state:
  - IDLE: pc<=T, go to REQ.
  - REQ, not accepted this cycle: request remains stable. pc<=T, drop<=1 (set at accept).
  - REQ, accepted same cycle: go to WAIT with drop=1, pc<=T.
  - WAIT: drop<=1. If imem_rsp_valid arrives the same cycle, that response is dropped and the FSM goes to REQ with pc=T.
  - HOLD: if_valid<=0, if_instr<=NOP_INSTR, go to REQ with pc=T. A coincident if_ready handshake is irrelevant because the IF/ID register flushes on redirect itself.
- Unexpected inputs:
  - imem_rsp_valid outside WAIT is ignored.
  - A second redirect while drop=1 only updates pc. At most one response is ever dropped.

Decomposition:
- Shared include yarc_if_defs.vh:
  - state encodings: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3.
  - NOP_INSTR, INSTR_BYTES, default RESET_VECTOR.
- Sub-module pc_next_sel: combinational priority mux (trap/redirect/increment) plus alignment and misaligned detect. The FSM and registers stay in pc_fetch_ctrl.

Test Plan:
- Boot: rst low 3 cycles, then high; imem_req_ready=1, 1-cycle response, if_ready=1 -> first request addr 0x0, then 0x4, 0x8; if_pc sequence 0,4,8 with matching if_instr.
- Backpressure: imem_req_ready low 4 cycles in REQ; if_ready low 5 cycles in HOLD -> imem_req_addr stable while not ready; if_valid/if_pc/if_instr held stable; no extra requests.
- Stale drop: redirect_valid, redirect_pc=0x200 in WAIT, response 0xDEAD_BEEF 2 cycles later -> response never appears on if_instr; next request addr 0x200.
- Priority/misalign: trap_valid with trap_pc=0x100 and redirect_valid with redirect_pc=0x203 in the same cycle -> next addr 0x100, misaligned_o=0; then redirect alone to 0x203 -> addr 0x200, misaligned_o pulses 1 cycle.
- Wrap and reset: pc at 0xFFFF_FFFC fetches, next addr 0x0; drive rst=0 during WAIT -> next cycle all outputs at reset values, refetch from RESET_VECTOR.
- HOLD kill: redirect to 0x40 while if_valid=1, if_ready=0 -> if_valid=0 next cycle, if_instr=0x0000_0013, next request addr 0x40.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the IF-stage fetch controller.
//   fetch_state_e : FSM encoding (IDLE=0, REQ=1, WAIT=2, HOLD=3)
//   DEFAULT_*     : default parameter values for pc_fetch_ctrl
//   align_word    : clears the byte-offset bits of an address
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned DEFAULT_INSTR_BYTES  = 4;
  localparam logic [31:0] DEFAULT_NOP_INSTR    = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/response plus the
// valid/ready delivery channel into the IF/ID register.
//   imem_req_valid/addr/ready : one-outstanding fetch request
//   imem_rsp_valid/data       : returned instruction word
//   if_valid/pc/instr/ready   : instruction handed to decode
// master = fetch controller, slave = memory + IF/ID side.
interface pc_fetch_ctrl_if;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output if_valid,
    output if_pc,
    output if_instr,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  if_valid,
    input  if_pc,
    input  if_instr,
    output if_ready
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch controller (purely combinational).
//   trap_valid/trap_pc         : highest-priority redirect
//   redirect_valid/redirect_pc : branch/jump redirect
//   cur_pc                     : current architectural fetch PC
//   take                       : a redirect is being applied this cycle
//   next_pc                    : word-aligned target, or cur_pc + INSTR_BYTES
//   misaligned                 : selected target had non-zero byte offset
module pc_next_sel
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] cur_pc,
  output logic        take,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] target;

  always_comb begin
    take       = trap_valid | redirect_valid;
    target     = trap_valid ? trap_pc : redirect_pc;
    misaligned = take && (target[1:0] != 2'b00);
    // Sequential increment wraps naturally at 2^32.
    next_pc    = take ? align_word(target) : (cur_pc + 32'(INSTR_BYTES));
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage controller: owns the fetch PC, issues one outstanding imem request
// at a time, hands each instruction to IF/ID with valid/ready, and applies
// trap/branch redirects, discarding the response of any stale in-flight fetch.
//   clk, rst            : clock, synchronous active-low reset
//   redirect_valid/pc   : branch/jump redirect from EX
//   trap_valid/pc       : trap redirect (wins over redirect_valid)
//   misaligned_o        : one-cycle pulse when an applied target was unaligned
//   bus (master)        : imem request/response and IF/ID delivery channel
// All outputs are registered.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned INSTR_BYTES  = DEFAULT_INSTR_BYTES,
  parameter logic [31:0] NOP_INSTR    = DEFAULT_NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   trap_valid,
  input  logic [31:0]            trap_pc,
  output logic                   misaligned_o,
  pc_fetch_ctrl_if.master        bus
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  fetch_pc;
  logic         drop;

  logic         take;
  logic [31:0]  next_pc;
  logic         mis;

  pc_next_sel #(
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .cur_pc         (pc),
    .take           (take),
    .next_pc        (next_pc),
    .misaligned     (mis)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= StIdle;
      pc                 <= RESET_VECTOR;
      fetch_pc           <= RESET_VECTOR;
      drop               <= 1'b0;
      bus.imem_req_valid <= 1'b0;
      bus.imem_req_addr  <= RESET_VECTOR;
      bus.if_valid       <= 1'b0;
      bus.if_pc          <= 32'h0;
      bus.if_instr       <= NOP_INSTR;
      misaligned_o       <= 1'b0;
    end else begin
      misaligned_o <= mis;

      unique case (state)
        StIdle: begin
          pc                 <= take ? next_pc : pc;
          bus.imem_req_addr  <= take ? next_pc : pc;
          bus.imem_req_valid <= 1'b1;
          state              <= StReq;
        end

        StReq: begin
          if (bus.imem_req_valid && bus.imem_req_ready) begin
            // The address on the bus is what memory will answer for; pc may
            // already hold a redirect target if drop is set.
            fetch_pc           <= bus.imem_req_addr;
            bus.imem_req_valid <= 1'b0;
            state              <= StWait;
            // With drop set, pc already holds the redirect target: keep it.
            if (take || !drop) begin
              pc <= next_pc;
            end
            if (take) begin
              drop <= 1'b1;
            end
          end else if (take) begin
            // Request stays on the bus unchanged; its answer will be thrown away.
            pc   <= next_pc;
            drop <= 1'b1;
          end
        end

        StWait: begin
          if (bus.imem_rsp_valid) begin
            if (drop || take) begin
              drop               <= 1'b0;
              pc                 <= take ? next_pc : pc;
              bus.imem_req_addr  <= take ? next_pc : pc;
              bus.imem_req_valid <= 1'b1;
              state              <= StReq;
            end else begin
              bus.if_valid <= 1'b1;
              bus.if_pc    <= fetch_pc;
              bus.if_instr <= bus.imem_rsp_data;
              state        <= StHold;
            end
          end else if (take) begin
            pc   <= next_pc;
            drop <= 1'b1;
          end
        end

        StHold: begin
          if (take) begin
            // IF/ID flushes itself on redirect, so a coincident if_ready is moot.
            bus.if_valid       <= 1'b0;
            bus.if_instr       <= NOP_INSTR;
            pc                 <= next_pc;
            bus.imem_req_addr  <= next_pc;
            bus.imem_req_valid <= 1'b1;
            state              <= StReq;
          end else if (bus.if_valid && bus.if_ready) begin
            bus.if_valid       <= 1'b0;
            bus.imem_req_addr  <= pc;
            bus.imem_req_valid <= 1'b1;
            state              <= StReq;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
